// File: rtl/gcd_stein_hs.sv
// rtl/gcd_stein_hs.sv - binary (Stein) GCD engine, one shift/subtract step per clock
module gcd_stein_hs #(
    parameter int  DATA_WIDTH = 8,
    localparam int CNT_W      = $clog2(2 * DATA_WIDTH + 2),
    localparam int K_W        = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] gcd_o,
    output logic                  zero_o,
    output logic [CNT_W-1:0]      cycles_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] gcd_q, gcd_d;
    logic                  zero_q, zero_d;
    logic [CNT_W-1:0]      cycles_q, cycles_d;

    logic [DATA_WIDTH-1:0] diff_ab;
    logic [DATA_WIDTH-1:0] diff_ba;
    logic [CNT_W-1:0]      cnt_inc;

    // Only the positive difference is ever selected, so wrap-around never reaches the registers.
    assign diff_ab = a_q - b_q;
    assign diff_ba = b_q - a_q;
    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            gcd_q    <= '0;
            zero_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            gcd_q    <= gcd_d;
            zero_q   <= zero_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        gcd_d    = gcd_q;
        zero_d   = zero_q;
        cycles_d = cycles_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d   = operand_a_i;
                    b_d   = operand_b_i;
                    k_d   = '0;
                    cnt_d = '0;
                    // A zero operand short-circuits straight to DONE with zero iterations.
                    if (operand_a_i == '0 && operand_b_i == '0) begin
                        gcd_d    = '0;
                        zero_d   = 1'b1;
                        cycles_d = '0;
                        state_d  = S_DONE;
                    end else if (operand_a_i == '0) begin
                        gcd_d    = operand_b_i;
                        zero_d   = 1'b0;
                        cycles_d = '0;
                        state_d  = S_DONE;
                    end else if (operand_b_i == '0) begin
                        gcd_d    = operand_a_i;
                        zero_d   = 1'b0;
                        cycles_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                cnt_d = cnt_inc;
                if (a_q == b_q) begin
                    gcd_d    = a_q << k_q;
                    zero_d   = 1'b0;
                    cycles_d = cnt_inc;
                    state_d  = S_DONE;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = diff_ab >> 1;
                end else begin
                    b_d = diff_ba >> 1;
                end
            end

            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign gcd_o       = gcd_q;
    assign zero_o      = zero_q;
    assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_gcd_stein_hs.sv
// tb/tb_gcd_stein_hs.sv - self-checking bench for gcd_stein_hs at widths 4, 8 and 16
module tb_gcd_stein_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid_a  [3];
    logic [15:0] op_a_a      [3];
    logic [15:0] op_b_a      [3];
    logic        out_ready_a [3];
    logic        in_ready_a  [3];
    logic        out_valid_a [3];
    logic        zero_a      [3];
    logic        busy_a      [3];
    logic [15:0] gcd_a       [3];
    logic [7:0]  cyc_a       [3];

    logic [3:0]  gcd4;
    logic [3:0]  cyc4;
    logic [7:0]  gcd8;
    logic [4:0]  cyc8;
    logic [15:0] gcd16;
    logic [5:0]  cyc16;

    gcd_stein_hs #(.DATA_WIDTH(4)) dut4 (
        .clk_i(clk), .reset_i(reset),
        .in_valid_i(in_valid_a[0]), .in_ready_o(in_ready_a[0]),
        .operand_a_i(op_a_a[0][3:0]), .operand_b_i(op_b_a[0][3:0]),
        .out_valid_o(out_valid_a[0]), .out_ready_i(out_ready_a[0]),
        .gcd_o(gcd4), .zero_o(zero_a[0]), .cycles_o(cyc4), .busy_o(busy_a[0])
    );

    gcd_stein_hs #(.DATA_WIDTH(8)) dut8 (
        .clk_i(clk), .reset_i(reset),
        .in_valid_i(in_valid_a[1]), .in_ready_o(in_ready_a[1]),
        .operand_a_i(op_a_a[1][7:0]), .operand_b_i(op_b_a[1][7:0]),
        .out_valid_o(out_valid_a[1]), .out_ready_i(out_ready_a[1]),
        .gcd_o(gcd8), .zero_o(zero_a[1]), .cycles_o(cyc8), .busy_o(busy_a[1])
    );

    gcd_stein_hs #(.DATA_WIDTH(16)) dut16 (
        .clk_i(clk), .reset_i(reset),
        .in_valid_i(in_valid_a[2]), .in_ready_o(in_ready_a[2]),
        .operand_a_i(op_a_a[2]), .operand_b_i(op_b_a[2]),
        .out_valid_o(out_valid_a[2]), .out_ready_i(out_ready_a[2]),
        .gcd_o(gcd16), .zero_o(zero_a[2]), .cycles_o(cyc16), .busy_o(busy_a[2])
    );

    assign gcd_a[0] = 16'(gcd4);
    assign gcd_a[1] = 16'(gcd8);
    assign gcd_a[2] = gcd16;
    assign cyc_a[0] = 8'(cyc4);
    assign cyc_a[1] = 8'(cyc8);
    assign cyc_a[2] = 8'(cyc16);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Euclid by remainder: deliberately a different algorithm from the engine.
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Number of iterations the step rules take, counting the terminating a==b step.
    function automatic int ref_steps(input int a, input int b);
        int n;
        if (a == 0 || b == 0) return 0;
        n = 0;
        forever begin
            n++;
            if (a == b) break;
            if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
            else if (a % 2 == 0) a = a / 2;
            else if (b % 2 == 0) b = b / 2;
            else if (a > b) a = (a - b) / 2;
            else b = (b - a) / 2;
        end
        return n;
    endfunction

    // One full transaction; lat counts clock edges from the accept edge to out_valid_o.
    task automatic run_txn(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input int hold, output logic [15:0] g, output logic z,
                           output logic [7:0] c, output int lat);
        int n;
        @(negedge clk);
        op_a_a[idx]     = a;
        op_b_a[idx]     = b;
        in_valid_a[idx] = 1'b1;
        n = 0;
        while (!in_ready_a[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 50), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid_a[idx] = 1'b0;
        lat = 1;
        while (!out_valid_a[idx] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("valid_wait", 32'(out_valid_a[idx]), 1);
        g = gcd_a[idx];
        z = zero_a[idx];
        c = cyc_a[idx];
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(out_valid_a[idx]), 1);
            check("hold_gcd", 32'(gcd_a[idx]), 32'(g));
            check("hold_cycles", 32'(cyc_a[idx]), 32'(c));
            check("hold_in_ready", 32'(in_ready_a[idx]), 0);
            @(negedge clk);
        end
        out_ready_a[idx] = 1'b1;
        @(negedge clk);
        out_ready_a[idx] = 1'b0;
        check("valid_drop", 32'(out_valid_a[idx]), 0);
        check("in_ready_back", 32'(in_ready_a[idx]), 1);
    endtask

    task automatic sweep(input int idx, input int w, input int count);
        logic [15:0] mask;
        logic [15:0] a, b, g;
        logic        z;
        logic [7:0]  c;
        int          lat, r, exp_c;
        mask = (16'h1 << w) - 16'h1;
        for (int i = 0; i < count; i++) begin
            a = 16'($urandom) & mask;
            b = 16'($urandom) & mask;
            r = $urandom_range(0, 15);
            if (r == 0) a = 16'h0;
            if (r == 1) b = 16'h0;
            if (r == 2) b = a;
            if (r == 3) begin a = 16'h0; b = 16'h0; end
            run_txn(idx, a, b, $urandom_range(0, 3), g, z, c, lat);
            exp_c = ref_steps(int'(a), int'(b));
            check("rnd_gcd", 32'(g), 32'(ref_gcd(int'(a), int'(b))));
            check("rnd_zero", 32'(z), 32'(a == 0 && b == 0));
            check("rnd_cycles", 32'(c), 32'(exp_c));
            check("rnd_cycle_bound", 32'(int'(c) <= 2 * w + 1), 1);
            check("rnd_latency", 32'(lat), 32'(exp_c + 1));
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] gcd;
        logic        zero;
        int          cyc;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #900000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] g;
        logic        z;
        logic [7:0]  c;
        int          lat, n;

        vecs.push_back('{16'd48,  16'd18,  16'd6,   1'b0, 6, 0});
        vecs.push_back('{16'd255, 16'd1,   16'd1,   1'b0, 8, 1});
        vecs.push_back('{16'd1,   16'd255, 16'd1,   1'b0, 8, 0});
        vecs.push_back('{16'd7,   16'd7,   16'd7,   1'b0, 1, 2});
        vecs.push_back('{16'd0,   16'd12,  16'd12,  1'b0, 0, 0});
        vecs.push_back('{16'd12,  16'd0,   16'd12,  1'b0, 0, 1});
        vecs.push_back('{16'd0,   16'd0,   16'd0,   1'b1, 0, 0});
        vecs.push_back('{16'd64,  16'd96,  16'd32,  1'b0, 8, 0});
        vecs.push_back('{16'd128, 16'd128, 16'd128, 1'b0, 1, 0});
        vecs.push_back('{16'd100, 16'd75,  16'd25,  1'b0, 4, 3});

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            op_a_a[i]      = 16'h0;
            op_b_a[i]      = 16'h0;
            out_ready_a[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 32'(in_ready_a[i]), 1);
            check("rst_out_valid", 32'(out_valid_a[i]), 0);
            check("rst_gcd", 32'(gcd_a[i]), 0);
            check("rst_zero", 32'(zero_a[i]), 0);
            check("rst_cycles", 32'(cyc_a[i]), 0);
            check("rst_busy", 32'(busy_a[i]), 0);
        end

        foreach (vecs[i]) begin
            run_txn(1, vecs[i].a, vecs[i].b, vecs[i].hold, g, z, c, lat);
            check("vec_gcd", 32'(g), 32'(vecs[i].gcd));
            check("vec_zero", 32'(z), 32'(vecs[i].zero));
            check("vec_cycles", 32'(c), 32'(vecs[i].cyc));
            check("vec_latency", 32'(lat), 32'(vecs[i].cyc + 1));
        end

        // Back-pressure: result held five cycles while a competing pair is offered.
        @(negedge clk);
        op_a_a[1] = 16'd100; op_b_a[1] = 16'd75; in_valid_a[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[1] = 1'b0;
        n = 1;
        while (!out_valid_a[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 32'(n), 5);
        op_a_a[1] = 16'd9; op_b_a[1] = 16'd6; in_valid_a[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid_a[1]), 1);
            check("bp_gcd", 32'(gcd_a[1]), 25);
            check("bp_in_ready", 32'(in_ready_a[1]), 0);
            check("bp_busy", 32'(busy_a[1]), 1);
            @(negedge clk);
        end
        in_valid_a[1]  = 1'b0;
        out_ready_a[1] = 1'b1;
        @(negedge clk);
        out_ready_a[1] = 1'b0;
        check("bp_release_valid", 32'(out_valid_a[1]), 0);
        check("bp_release_in_ready", 32'(in_ready_a[1]), 1);
        check("bp_release_gcd", 32'(gcd_a[1]), 25);
        @(negedge clk);
        check("bp_no_accept", 32'(busy_a[1]), 0);

        // Reset during the third CALC cycle abandons the transaction.
        op_a_a[1] = 16'd48; op_b_a[1] = 16'd18; in_valid_a[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rc_no_valid", 32'(out_valid_a[1]), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rc_in_ready", 32'(in_ready_a[1]), 1);
        check("rc_out_valid", 32'(out_valid_a[1]), 0);
        check("rc_gcd", 32'(gcd_a[1]), 0);
        check("rc_zero", 32'(zero_a[1]), 0);
        check("rc_cycles", 32'(cyc_a[1]), 0);
        check("rc_busy", 32'(busy_a[1]), 0);
        repeat (10) begin
            @(negedge clk);
            check("rc_stays_idle", 32'(out_valid_a[1]), 0);
        end
        run_txn(1, 16'd9, 16'd6, 0, g, z, c, lat);
        check("rc_next_gcd", 32'(g), 3);
        check("rc_next_cycles", 32'(c), 3);

        fork
            sweep(0, 4, 1000);
            sweep(1, 8, 1000);
            sweep(2, 16, 1000);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
